muldiv: RTL and testbench

Iterative signed multiply / divide / modulo unit for the ConfusedCore HMMM execute stage. It sits beside the single-cycle add/sub ALU. It takes the same two 16-bit register operands from operand select, stalls the pipeline while it iterates, and hands a 16-bit result to the writeback mux. It implements the HMMM `mul`, `div` and `mod` semantics, which are Python-style floor division and modulo.

---
 rtl/hmmm_pkg.sv | 27 ++
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv.sv | 167 ++++++++++++++++
 tb/tb_muldiv.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/hmmm_pkg.sv
// Shared types and constants for the HMMM iterative multiply/divide unit.
package hmmm_pkg;

    localparam int WORD_W   = 16;
    localparam int MD_ITERS = 16;
    localparam int CNT_W    = $clog2(MD_ITERS);

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_DIV  = 2'b01,
        MD_MOD  = 2'b10,
        MD_RSVD = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdState_t;

    // Two's-complement magnitude; 0x8000 maps to itself and is read as unsigned.
    function automatic logic [WORD_W-1:0] mag(input logic [WORD_W-1:0] v);
        return v[WORD_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between operand select, the muldiv unit and writeback.
interface muldiv_if;
    import hmmm_pkg::*;

    logic              start;
    logic [1:0]        op;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] result;
    logic              divZero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, divZero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, divZero
    );

endinterface

// File: rtl/muldiv.sv
// Iterative signed mul / floor-div / floor-mod, 16 iterations plus one sign-fix cycle.
// Mul and div share the accumulator/remainder and the two operand shift registers.
module muldiv
    import hmmm_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  md
);

    mdState_t          state_reg;
    mdOp_t             op_reg;
    logic [WORD_W-1:0] acc_reg;     // mul: partial product, div: remainder
    logic [WORD_W-1:0] x_reg;       // mul: multiplicand, div: dividend -> quotient
    logic [WORD_W-1:0] y_reg;       // mul: multiplier, div: |divisor|
    logic [WORD_W-1:0] b_raw_reg;
    logic              a_neg_reg;
    logic              b_neg_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              div_zero_reg;
    logic [WORD_W-1:0] result_reg;

    mdOp_t             op_in;
    logic              op_in_is_div;
    logic              is_div;

    always_comb begin
        op_in        = mdOp_t'(md.op);
        op_in_is_div = (op_in == MD_DIV) || (op_in == MD_MOD);
        is_div       = (op_reg == MD_DIV) || (op_reg == MD_MOD);
    end

    logic [WORD_W:0]   rem_shift;
    logic [WORD_W:0]   rem_trial;
    logic [WORD_W-1:0] acc_next;
    logic [WORD_W-1:0] x_next;
    logic [WORD_W-1:0] y_next;

    // One iteration of either restoring division or shift-add multiply.
    always_comb begin
        rem_shift = {acc_reg, x_reg[WORD_W-1]};
        rem_trial = rem_shift - {1'b0, y_reg};
        acc_next  = acc_reg;
        x_next    = x_reg;
        y_next    = y_reg;
        if (is_div) begin
            if (!rem_trial[WORD_W]) begin
                acc_next = rem_trial[WORD_W-1:0];
                x_next   = {x_reg[WORD_W-2:0], 1'b1};
            end else begin
                acc_next = rem_shift[WORD_W-1:0];
                x_next   = {x_reg[WORD_W-2:0], 1'b0};
            end
        end else begin
            if (y_reg[0]) begin
                acc_next = acc_reg + x_reg;
            end
            x_next = {x_reg[WORD_W-2:0], 1'b0};
            y_next = {1'b0, y_reg[WORD_W-1:1]};
        end
    end

    logic              signs_differ;
    logic [WORD_W-1:0] r_signed;
    logic [WORD_W-1:0] fix_value;

    // Convert truncating |a|/|b| results into floor semantics.
    always_comb begin
        signs_differ = a_neg_reg ^ b_neg_reg;
        r_signed     = a_neg_reg ? -acc_reg : acc_reg;
        fix_value    = acc_reg;
        case (op_reg)
            MD_DIV: begin
                if (signs_differ && (acc_reg != '0)) begin
                    fix_value = ~x_reg;
                end else if (signs_differ) begin
                    fix_value = -x_reg;
                end else begin
                    fix_value = x_reg;
                end
            end
            MD_MOD: begin
                if ((r_signed != '0) && signs_differ) begin
                    fix_value = r_signed + b_raw_reg;
                end else begin
                    fix_value = r_signed;
                end
            end
            default: fix_value = acc_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= MD_MUL;
            acc_reg      <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            b_raw_reg    <= '0;
            a_neg_reg    <= 1'b0;
            b_neg_reg    <= 1'b0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            result_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (md.start) begin
                        op_reg    <= op_in;
                        a_neg_reg <= md.a[WORD_W-1];
                        b_neg_reg <= md.b[WORD_W-1];
                        b_raw_reg <= md.b;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        if (op_in_is_div) begin
                            x_reg <= mag(md.a);
                            y_reg <= mag(md.b);
                        end else begin
                            x_reg <= md.a;
                            y_reg <= md.b;
                        end
                        if (op_in_is_div && (md.b == '0)) begin
                            state_reg    <= DONE;
                            done_reg     <= 1'b1;
                            result_reg   <= '0;
                            div_zero_reg <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    x_reg   <= x_next;
                    y_reg   <= y_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(MD_ITERS - 1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    state_reg    <= DONE;
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b1;
                    result_reg   <= fix_value;
                    div_zero_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign md.busy    = busy_reg;
    assign md.done    = done_reg;
    assign md.result  = result_reg;
    assign md.divZero = div_zero_reg;

endmodule

// File: tb/tb_muldiv.sv
// Directed checks of muldiv: values, latency, busy shape, protocol and reset abort.
module tb_muldiv;
    import hmmm_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    muldiv_if md();

    muldiv dut (
        .clk   (clk),
        .reset (reset),
        .md    (md.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Issues one op (start high in cycle 0) and follows it until done or timeout.
    task automatic run_op(input string tag, input logic [1:0] op_i, input logic [15:0] a_i,
                          input logic [15:0] b_i, input logic [15:0] exp_res, input logic exp_dz,
                          input int exp_lat, input int pulse_cyc);
        int lat;
        int busy_err;
        logic [15:0] res;
        logic dz;
        logic busy_at_done;
        lat = 0; busy_err = 0; res = 'x; dz = 'x; busy_at_done = 'x;
        @(negedge clk);
        md.start = 1'b1; md.op = op_i; md.a = a_i; md.b = b_i;
        @(posedge clk); #1;
        md.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (md.done) begin
                lat = k; res = md.result; dz = md.divZero; busy_at_done = md.busy;
                break;
            end
            if (md.busy !== (!exp_dz && k <= 17)) busy_err++;
            if (k == pulse_cyc) begin
                md.start = 1'b1; md.op = 2'b01; md.a = 16'h1234; md.b = 16'h0000;
            end else begin
                md.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        md.start = 1'b0;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, res, exp_res);
        check({tag, " divZero"}, dz, exp_dz);
        check({tag, " busy_shape"}, busy_err, 0);
        check({tag, " busy_at_done"}, busy_at_done, 1'b0);
    endtask

    initial begin
        int first_done, second_done, n_done;
        logic [15:0] res1, res2;
        n_checks = 0; n_pass = 0;
        reset = 1'b1;
        md.start = 1'b0; md.op = 2'b00; md.a = '0; md.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", md.busy, 1'b0);
        check("reset done", md.done, 1'b0);
        check("reset result", md.result, 16'h0000);
        check("reset divZero", md.divZero, 1'b0);
        reset = 1'b0;

        run_op("mul -3*7", 2'b00, 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 18, 0);
        run_op("div -7/2", 2'b01, 16'hFFF9, 16'h0002, 16'hFFFC, 1'b0, 18, 0);
        run_op("mod -7%2", 2'b10, 16'hFFF9, 16'h0002, 16'h0001, 1'b0, 18, 0);
        run_op("div 7/-2", 2'b01, 16'h0007, 16'hFFFE, 16'hFFFC, 1'b0, 18, 0);
        run_op("mod 7%-2", 2'b10, 16'h0007, 16'hFFFE, 16'hFFFF, 1'b0, 18, 0);
        run_op("div 6/-3", 2'b01, 16'h0006, 16'hFFFD, 16'hFFFE, 1'b0, 18, 0);
        run_op("mod 6%-3", 2'b10, 16'h0006, 16'hFFFD, 16'h0000, 1'b0, 18, 0);
        run_op("div min/-1", 2'b01, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 18, 0);
        run_op("mod min%-1", 2'b10, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 18, 0);
        run_op("mul 4000*4", 2'b00, 16'h4000, 16'h0004, 16'h0000, 1'b0, 18, 0);
        run_op("div 100/7", 2'b01, 16'd100, 16'd7, 16'd14, 1'b0, 18, 0);
        run_op("div -100/7", 2'b01, 16'hFF9C, 16'd7, 16'hFFF1, 1'b0, 18, 0);
        run_op("mod -100%7", 2'b10, 16'hFF9C, 16'd7, 16'd5, 1'b0, 18, 0);
        run_op("div 5/0", 2'b01, 16'd5, 16'd0, 16'h0000, 1'b1, 1, 0);
        run_op("mul 2*3", 2'b00, 16'd2, 16'd3, 16'd6, 1'b0, 18, 0);

        repeat (3) @(posedge clk);
        #1;
        check("hold result", md.result, 16'd6);
        check("hold done", md.done, 1'b0);

        run_op("rsvd 2*3", 2'b11, 16'd2, 16'd3, 16'd6, 1'b0, 18, 0);
        run_op("pulse mul 5*5", 2'b00, 16'd5, 16'd5, 16'd25, 1'b0, 18, 5);

        // Back-to-back: start held high through the first DONE cycle.
        first_done = 0; second_done = 0; n_done = 0; res1 = '0; res2 = '0;
        @(negedge clk);
        md.start = 1'b1; md.op = 2'b00; md.a = 16'd2; md.b = 16'd3;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (md.done) begin
                n_done++;
                if (n_done == 1) begin first_done = k; res1 = md.result; end
                if (n_done == 2) begin second_done = k; res2 = md.result; end
            end
            if (k == 18) begin md.op = 2'b01; md.a = 16'd100; md.b = 16'd7; end
            if (k == 36) md.start = 1'b0;
        end
        md.start = 1'b0;
        check("b2b first done cycle", first_done, 18);
        check("b2b first result", res1, 16'd6);
        check("b2b second done cycle", second_done, 36);
        check("b2b second result", res2, 16'd14);
        check("b2b done count", n_done, 2);

        // Reset in cycle 10 of a div discards it.
        @(negedge clk);
        md.start = 1'b1; md.op = 2'b01; md.a = 16'd100; md.b = 16'd7;
        @(posedge clk); #1;
        md.start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        check("abort busy c10", md.busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy c11", md.busy, 1'b0);
        check("abort done c11", md.done, 1'b0);
        check("abort result c11", md.result, 16'h0000);
        check("abort divZero c11", md.divZero, 1'b0);
        n_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (md.done) n_done++;
        end
        check("abort no done", n_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
